change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Pays out change amounts issued by the vending machine controller, one coin at a time, through a coin hopper.
- Takes a change amount over a valid/ready handshake and breaks it into 2-unit and 1-unit coins, preferring 2-unit coins.
- Drives a req/ack handshake to the hopper and tracks the coin inventory of each denomination.
- Refuses any amount it cannot pay exactly.

Parameters:
- AMT_W, 3: width of change amount in coin units (max amount 2^AMT_W-1).
- CNT_W, 4: width of each inventory counter.
- INIT_CNT1, 8: 1-unit coin count loaded at reset and on refill.
- INIT_CNT2, 8: 2-unit coin count loaded at reset and on refill.
- TIMEOUT_CYC, 15: hopper ack timeout in cycles; used only with HOPPER_TIMEOUT_EN.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- chg_valid, input, 1: change request valid.
- chg_amt, input, AMT_W: change amount in units.
- chg_ready, output, 1: dispenser can accept a request.
- coin_req, output, 1: hopper request; eject one coin.
- coin_sel, output, 1: 1 = 2-unit coin, 0 = 1-unit coin; stable while coin_req is high.
- coin_ack, input, 1: hopper has ejected the requested coin.
- refill, input, 1: reload both counters to INIT values.
- done, output, 1: one-cycle pulse; request fully paid.
- short, output, 1: one-cycle pulse; request rejected, insufficient coins.
- cnt1, output, CNT_W: 1-unit coins in stock.
- cnt2, output, CNT_W: 2-unit coins in stock.
- hopper_fault, output, 1: present only with HOPPER_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, coin_req=0, coin_sel=0, done=0, short=0, cnt1=INIT_CNT1, cnt2=INIT_CNT2, remaining=0.
- Reset mid-operation: abandons the transfer. coin_req is low from the next cycle. No done or short pulse.
- FSM states: IDLE, SEL, REQ, DONE.
- chg_ready = (state==IDLE) && !refill. This is combinational.
- Accept: chg_valid && chg_ready at a rising edge.
- Payability check, evaluated at accept: payable when 2*min(cnt2, amt>>1) + cnt1 >= amt.
- IDLE, on accept:
  - amt==0: go to DONE.
  - Not payable: short=1 for the next cycle, stay in IDLE, counters unchanged.
  - Otherwise: remaining=amt, go to SEL.
- IDLE, refill=1: cnt1=INIT_CNT1 and cnt2=INIT_CNT2 at that edge. refill is ignored in every other state.
- SEL:
  - remaining==0: go to DONE.
  - Otherwise: coin_sel = (remaining>=2 && cnt2!=0) ? 1 : 0, registered; go to REQ.
- REQ:
  - coin_req = 1 (Moore output); coin_sel is held.
  - On coin_ack=1: decrement the selected counter and subtract 1 or 2 from remaining; go to SEL.
  - coin_req is therefore low for at least one cycle between coins.
- DONE: done=1 for one cycle, then go to IDLE.
- coin_ack outside REQ is ignored.
- Counters never underflow. The payability check guarantees enough stock, and the SEL choice falls back to 1-unit coins when cnt2==0.
- Latency, accept at edge N with hopper acking the same cycle coin_req rises: first coin_req high in cycle N+2; each coin takes 2 cycles.

Optional Feature:
- Macro: HOPPER_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ and clears when leaving REQ.
  - If TIMEOUT_CYC cycles pass without coin_ack: coin_req drops and hopper_fault=1 for one cycle.
  - Remaining change is discarded, no done pulse, state goes to IDLE.
  - Coins already acked stay deducted from the counters.
- Not defined: no hopper_fault port; REQ waits for coin_ack indefinitely.

Test Plan:
1. Defaults 8/8; amt=5, coin_ack one cycle after each coin_req rise -> coin_sel sequence 1,1,0; cnt2=6, cnt1=7; done pulses once; chg_ready high again the cycle after done.
2. INIT_CNT2=0, amt=3 -> three coins with coin_sel=0; cnt1=5; done pulse.
3. INIT_CNT1=1, INIT_CNT2=1:
   - amt=4 -> short pulse the next cycle, no coin_req, counts stay 1/1.
   - Then amt=3 -> coins 1,0, counts 0/0, done pulse.
4. amt=0 -> done high exactly one cycle, one cycle after accept; coin_req never rises; counts unchanged.
5. Two 2-unit coins already acked (counts 8/6), then rst asserted while in REQ -> coin_req=0 next cycle; cnt1=8, cnt2=8; chg_ready=1; no done pulse.
6. Counts reduced to 7/6, then refill=1 and chg_valid=1 (amt=2) in the same IDLE cycle -> request not accepted (chg_ready=0); counts return to 8/8; request accepted on the next cycle.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: breaks a change amount into 2-unit and 1-unit coins
// (2-unit preferred), pays them out one at a time over a req/ack hopper
// handshake and keeps the stock count of each denomination.
//
// Optional build macro: HOPPER_TIMEOUT_EN
//   When defined, a hopper that does not ack within TIMEOUT_CYC cycles
//   aborts the payout and raises a one-cycle hopper_fault pulse.
//
// Handshakes:
//   chg_valid/chg_ready : a request is taken on a rising edge where both
//                         are high; chg_amt is sampled at that edge.
//   coin_req/coin_ack   : coin_req stays high (coin_sel stable) until the
//                         edge where coin_ack is seen; coin_req then drops
//                         for at least one cycle before the next coin.
module change_dispenser #(
   parameter int unsigned AMT_W       = 3,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned INIT_CNT1   = 8,
   parameter int unsigned INIT_CNT2   = 8,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chg_valid,
   input  logic [AMT_W-1:0] chg_amt,
   output logic             chg_ready,
   output logic             coin_req,
   output logic             coin_sel,
   input  logic             coin_ack,
   input  logic             refill,
   output logic             done,
   output logic             short,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2
`ifdef HOPPER_TIMEOUT_EN
   ,
   output logic             hopper_fault
`endif
);

   // Wide enough for 2*cnt2 + cnt1 without overflow.
   localparam int unsigned SUM_W = ((CNT_W > AMT_W) ? CNT_W : AMT_W) + 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      REQ  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [AMT_W-1:0] remaining;
   logic [AMT_W-1:0] remaining_nxt;
   logic [CNT_W-1:0] cnt1_nxt;
   logic [CNT_W-1:0] cnt2_nxt;
   logic             coin_sel_nxt;
   logic             short_nxt;
   logic             payable;
   logic [SUM_W-1:0] half_amt;
   logic [SUM_W-1:0] use2;
   logic [SUM_W-1:0] pay_cap;

`ifdef HOPPER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;
   logic             fault_nxt;
`endif

   // Moore outputs and the request-side ready.
   assign chg_ready = (state == IDLE) && !refill;
   assign coin_req  = (state == REQ);
   assign done      = (state == DONE);

   // Payability: use as many 2-unit coins as both stock and amount allow,
   // then the 1-unit stock must cover the rest.
   always_comb begin
      half_amt = SUM_W'(chg_amt >> 1);
      use2     = (SUM_W'(cnt2) < half_amt) ? SUM_W'(cnt2) : half_amt;
      pay_cap  = (use2 << 1) + SUM_W'(cnt1);
      payable  = (pay_cap >= SUM_W'(chg_amt));
   end

`ifdef HOPPER_TIMEOUT_EN
   // Timeout fires on the TIMEOUT_CYC-th REQ cycle that still has no ack.
   assign tmo_hit = (state == REQ) && !coin_ack &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`endif

   // Next-state, datapath updates and pulse outputs.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      cnt1_nxt      = cnt1;
      cnt2_nxt      = cnt2;
      coin_sel_nxt  = coin_sel;
      short_nxt     = 1'b0;
`ifdef HOPPER_TIMEOUT_EN
      fault_nxt     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (refill) begin
               cnt1_nxt = CNT_W'(INIT_CNT1);
               cnt2_nxt = CNT_W'(INIT_CNT2);
            end else if (chg_valid) begin
               if (chg_amt == '0) begin
                  state_nxt = DONE;
               end else if (!payable) begin
                  short_nxt = 1'b1;
               end else begin
                  remaining_nxt = chg_amt;
                  state_nxt     = SEL;
               end
            end
         end
         SEL: begin
            if (remaining == '0) begin
               state_nxt = DONE;
            end else begin
               // Fall back to 1-unit coins once 2-unit stock is empty.
               coin_sel_nxt = (remaining > AMT_W'(1)) && (cnt2 != '0);
               state_nxt    = REQ;
            end
         end
         REQ: begin
            if (coin_ack) begin
               if (coin_sel) begin
                  cnt2_nxt      = cnt2 - CNT_W'(1);
                  remaining_nxt = remaining - AMT_W'(2);
               end else begin
                  cnt1_nxt      = cnt1 - CNT_W'(1);
                  remaining_nxt = remaining - AMT_W'(1);
               end
               state_nxt = SEL;
            end
`ifdef HOPPER_TIMEOUT_EN
            else if (tmo_hit) begin
               // Abandon the rest of the payout; acked coins stay deducted.
               remaining_nxt = '0;
               fault_nxt     = 1'b1;
               state_nxt     = IDLE;
            end
`endif
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, stock counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         coin_sel  <= 1'b0;
         short     <= 1'b0;
         cnt1      <= CNT_W'(INIT_CNT1);
         cnt2      <= CNT_W'(INIT_CNT2);
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         coin_sel  <= coin_sel_nxt;
         short     <= short_nxt;
         cnt1      <= cnt1_nxt;
         cnt2      <= cnt2_nxt;
      end
   end

`ifdef HOPPER_TIMEOUT_EN
   // Hopper wait counter: runs only while staying in REQ, plus fault pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt      <= '0;
         hopper_fault <= 1'b0;
      end else begin
         hopper_fault <= fault_nxt;
         if ((state == REQ) && (state_nxt == REQ)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end else begin
            tmo_cnt <= '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized and directed stimulus for change_dispenser.
// Expected coin/done/short events are queued when a request is issued and
// popped by an independent monitor as the DUT produces them.
module tb_change_dispenser;

   localparam int AMT_W       = 3;
   localparam int CNT_W       = 4;
   localparam int INIT_CNT1   = 8;
   localparam int INIT_CNT2   = 8;
   localparam int TIMEOUT_CYC = 15;
   // Event word: {kind[1:0], sel, cnt1, cnt2}; kind 1=coin, 2=done, 3=short.
   localparam int W = 3 + 2 * CNT_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             chg_valid = 1'b0;
   logic [AMT_W-1:0] chg_amt = '0;
   logic             coin_ack = 1'b0;
   logic             refill = 1'b0;
   logic             chg_ready;
   logic             coin_req;
   logic             coin_sel;
   logic             done;
   logic             short;
   logic [CNT_W-1:0] cnt1;
   logic [CNT_W-1:0] cnt2;
`ifdef HOPPER_TIMEOUT_EN
   logic             hopper_fault;
`endif

   int         vectors = 0;
   int         miscompares = 0;
   logic [W-1:0] exp_q[$];
   int         m1 = INIT_CNT1;
   int         m2 = INIT_CNT2;
   int         hop_cnt = 0;
   int         hop_limit = 1 << 30;
   int         hop_dmax = 2;

   change_dispenser #(
      .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_CNT1(INIT_CNT1),
      .INIT_CNT2(INIT_CNT2), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .chg_valid(chg_valid), .chg_amt(chg_amt),
      .chg_ready(chg_ready), .coin_req(coin_req), .coin_sel(coin_sel),
      .coin_ack(coin_ack), .refill(refill), .done(done), .short(short),
      .cnt1(cnt1), .cnt2(cnt2)
`ifdef HOPPER_TIMEOUT_EN
      , .hopper_fault(hopper_fault)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [W-1:0] mk(input int kind, input int sel,
                                       input int c1, input int c2);
      logic [1:0]       k;
      logic             s;
      logic [CNT_W-1:0] a;
      logic [CNT_W-1:0] b;
      k = 2'(kind);
      s = 1'(sel);
      a = CNT_W'(c1);
      b = CNT_W'(c2);
      return {k, s, a, b};
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: greedy 2-unit split in closed form.
   task automatic push_req(input int amt);
      int n2;
      int n1;
      n2 = (m2 < amt / 2) ? m2 : amt / 2;
      n1 = amt - 2 * n2;
      if (amt != 0 && n1 > m1) begin
         exp_q.push_back(mk(3, 0, m1, m2));
      end else begin
         repeat (n2) exp_q.push_back(mk(1, 1, 0, 0));
         repeat (n1) exp_q.push_back(mk(1, 0, 0, 0));
         m2 = m2 - n2;
         m1 = m1 - n1;
         exp_q.push_back(mk(2, 0, m1, m2));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input int amt);
      int g;
      g = 0;
      @(negedge clk);
      while (!chg_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!chg_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL send_ready: chg_ready=%0b required 1", chg_ready);
      end else begin
         push_req(amt);
         chg_valid = 1'b1;
         chg_amt   = AMT_W'(amt);
         @(negedge clk);
         chg_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_refill();
      @(negedge clk);
      refill = 1'b1;
      @(negedge clk);
      refill = 1'b0;
      m1 = INIT_CNT1;
      m2 = INIT_CNT2;
   endtask

   task automatic pay(input int amt);
      send(amt);
      wait_drain();
   endtask

   // ---------------- hopper model ----------------
   initial begin
      int d;
      forever begin
         @(negedge clk);
         coin_ack = 1'b0;
         if (coin_req && !rst && hop_cnt < hop_limit) begin
            d = $urandom_range(0, hop_dmax);
            repeat (d) @(negedge clk);
            if (coin_req && !rst) begin
               coin_ack = 1'b1;
               hop_cnt++;
            end
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   task automatic check_evt(input string name, input logic [W-1:0] got);
      logic [W-1:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s: unexpected event got %h required none", name, got);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            miscompares++;
            $display("FAIL %s: got %h required %h at %0t", name, got, e, $time);
         end
      end
   endtask

   initial begin
      logic prev_req;
      logic prev_sel;
      prev_req = 1'b0;
      prev_sel = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            if (coin_req && !prev_req) check_evt("coin", mk(1, int'(coin_sel), 0, 0));
            if (coin_req && prev_req) begin
               vectors++;
               if (coin_sel !== prev_sel) begin
                  miscompares++;
                  $display("FAIL sel_hold: got %0b required %0b", coin_sel, prev_sel);
               end
            end
            if (done) check_evt("done", mk(2, 0, int'(cnt1), int'(cnt2)));
            if (short) check_evt("short", mk(3, 0, int'(cnt1), int'(cnt2)));
`ifdef HOPPER_TIMEOUT_EN
            if (hopper_fault) begin
               vectors++;
               miscompares++;
               $display("FAIL hopper_fault: got 1 required 0");
            end
`endif
         end
         prev_req = coin_req;
         prev_sel = coin_sel;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int g;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      // Reset state
      chk("rst_coin_req", int'(coin_req), 0);
      chk("rst_coin_sel", int'(coin_sel), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_short", int'(short), 0);
      chk("rst_cnt1", int'(cnt1), INIT_CNT1);
      chk("rst_cnt2", int'(cnt2), INIT_CNT2);
      chk("rst_ready", int'(chg_ready), 1);

      // amt=5 from 8/8: coins 1,1,0
      send(5);
      chk("lat_req_lo", int'(coin_req), 0);
      @(negedge clk);
      chk("lat_req_hi", int'(coin_req), 1);
      chk("lat_sel", int'(coin_sel), 1);
      wait_drain();
      chk("t1_done", int'(done), 1);
      @(negedge clk);
      chk("t1_done_off", int'(done), 0);
      chk("t1_ready", int'(chg_ready), 1);
      chk("t1_cnt1", int'(cnt1), 7);
      chk("t1_cnt2", int'(cnt2), 6);

      // amt=0: done one cycle after accept, no coins
      send(0);
      chk("z_done", int'(done), 1);
      @(negedge clk);
      chk("z_done_off", int'(done), 0);
      chk("z_ready", int'(chg_ready), 1);
      chk("z_cnt1", int'(cnt1), 7);
      chk("z_cnt2", int'(cnt2), 6);

      // Drain 2-unit stock, then 1-unit-only payouts
      do_refill();
      repeat (4) pay(4);
      chk("e2_cnt2", int'(cnt2), 0);
      pay(3);
      chk("e2_cnt1", int'(cnt1), 5);
      pay(2);
      chk("e2b_cnt1", int'(cnt1), 3);

      // Reach 1/1, then short and exact payout to empty
      do_refill();
      repeat (7) pay(1);
      pay(6);
      pay(6);
      pay(2);
      chk("s_cnt1", int'(cnt1), 1);
      chk("s_cnt2", int'(cnt2), 1);
      send(4);
      chk("s_short", int'(short), 1);
      chk("s_noreq", int'(coin_req), 0);
      @(negedge clk);
      chk("s_short_off", int'(short), 0);
      chk("s_cnt1b", int'(cnt1), 1);
      pay(3);
      chk("s_cnt1_0", int'(cnt1), 0);
      chk("s_cnt2_0", int'(cnt2), 0);
      pay(1);

      // Refill collides with a request in IDLE
      do_refill();
      pay(1);
      pay(4);
      chk("rf_cnt1", int'(cnt1), 7);
      chk("rf_cnt2", int'(cnt2), 6);
      @(negedge clk);
      @(negedge clk);
      refill    = 1'b1;
      chg_valid = 1'b1;
      chg_amt   = AMT_W'(2);
      #1;
      chk("rf_ready_lo", int'(chg_ready), 0);
      @(negedge clk);
      refill = 1'b0;
      m1 = INIT_CNT1;
      m2 = INIT_CNT2;
      chk("rf_cnt1_8", int'(cnt1), 8);
      chk("rf_cnt2_8", int'(cnt2), 8);
      #1;
      chk("rf_ready_hi", int'(chg_ready), 1);
      push_req(2);
      @(negedge clk);
      chg_valid = 1'b0;
      wait_drain();

      // Reset while waiting on the hopper after two 2-unit coins
      do_refill();
      hop_limit = hop_cnt + 2;
      send(7);
      g = 0;
      while (!(coin_req && cnt2 == CNT_W'(6)) && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("mr_req", int'(coin_req), 1);
      chk("mr_cnt1", int'(cnt1), 8);
      chk("mr_cnt2", int'(cnt2), 6);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("mr_req_lo", int'(coin_req), 0);
      chk("mr_done", int'(done), 0);
      chk("mr_cnt1_r", int'(cnt1), 8);
      chk("mr_cnt2_r", int'(cnt2), 8);
      chk("mr_ready", int'(chg_ready), 1);
      rst = 1'b0;
      hop_limit = 1 << 30;
      m1 = INIT_CNT1;
      m2 = INIT_CNT2;
      pay(3);

      // Randomized traffic
      repeat (150) begin
         if ($urandom_range(0, 4) == 0) do_refill();
         hop_dmax = $urandom_range(0, 3);
         pay($urandom_range(0, 7));
      end
      wait_drain();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
